// File: rtl/hqm_reset_pwr_sequencer.sv
// hqm_reset_pwr_sequencer: stages fuse pull, power-gate handshake and
// core/side reset release; handles warm-reset drain and forced power.
module hqm_reset_pwr_sequencer #(
    parameter int PWR_DLY   = 16,
    parameter int SIDE_DLY  = 8,
    parameter int FUSE_TMO  = 1023,
    parameter int DRAIN_TMO = 511
) (
    input  logic       prim_clk,
    input  logic       prim_rst_b,
    input  logic       pwr_on_req,
    input  logic       warm_rst_req,
    input  logic       fuse_bypass,
    input  logic       fuse_pull_ack,
    input  logic       pgcb_pwr_ack,
    input  logic       quiesce_done,
    input  logic       force_pwr_on,
    input  logic       force_pwr_off,
    output logic       fuse_pull_req,
    output logic       pgcb_pwr_req,
    output logic       quiesce_req,
    output logic       core_rst_b,
    output logic       side_rst_b,
    output logic       rst_done,
    output logic [1:0] seq_err,
    output logic [3:0] seq_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FUSE    = 4'd1,
        PWRUP   = 4'd2,
        PWRDLY  = 4'd3,
        CORE_UP = 4'd4,
        ACTIVE  = 4'd5,
        DRAIN   = 4'd6,
        PWRDN   = 4'd7,
        FORCED  = 4'd8
    } state_e;

    localparam logic [9:0] PWR_LAST   = 10'(PWR_DLY - 1);
    localparam logic [9:0] SIDE_LAST  = 10'(SIDE_DLY - 1);
    localparam logic [9:0] FUSE_LAST  = 10'(FUSE_TMO - 1);
    localparam logic [9:0] DRAIN_LAST = 10'(DRAIN_TMO - 1);

    state_e     state;
    state_e     state_nx;
    logic [9:0] cnt;
    logic [9:0] cnt_nx;
    logic [1:0] err_nx;
    logic       fuse_nx;
    logic       pgcb_nx;
    logic       qui_nx;
    logic       core_nx;
    logic       side_nx;
    logic       done_nx;
    logic       forced;

    assign forced    = force_pwr_on | force_pwr_off;
    assign seq_state = state;

    always_comb begin
        state_nx = state;
        err_nx   = seq_err;
        if (forced) begin
            state_nx = FORCED;
        end else begin
            case (state)
                IDLE: begin
                    if (pwr_on_req)
                        state_nx = fuse_bypass ? PWRUP : FUSE;
                end
                FUSE: begin
                    if (!pwr_on_req) begin
                        state_nx = PWRDN;
                    end else if (fuse_pull_ack) begin
                        state_nx = PWRUP;
                    end else if (cnt == FUSE_LAST) begin
                        state_nx  = PWRUP;
                        err_nx[0] = 1'b1;
                    end
                end
                PWRUP: begin
                    if (!pwr_on_req)
                        state_nx = PWRDN;
                    else if (pgcb_pwr_ack)
                        state_nx = PWRDLY;
                end
                PWRDLY: begin
                    if (!pwr_on_req)
                        state_nx = PWRDN;
                    else if (!pgcb_pwr_ack)
                        state_nx = PWRUP;
                    else if (cnt == PWR_LAST)
                        state_nx = CORE_UP;
                end
                CORE_UP: begin
                    if (!pwr_on_req)
                        state_nx = PWRDN;
                    else if (!pgcb_pwr_ack)
                        state_nx = PWRUP;
                    else if (cnt == SIDE_LAST)
                        state_nx = ACTIVE;
                end
                ACTIVE: begin
                    if (!pwr_on_req)
                        state_nx = PWRDN;
                    else if (!pgcb_pwr_ack)
                        state_nx = PWRUP;
                    else if (warm_rst_req)
                        state_nx = DRAIN;
                end
                DRAIN: begin
                    if (!pwr_on_req) begin
                        state_nx = PWRDN;
                    end else if (!pgcb_pwr_ack) begin
                        state_nx = PWRUP;
                    end else if (quiesce_done) begin
                        state_nx = PWRDLY;
                    end else if (cnt == DRAIN_LAST) begin
                        state_nx  = PWRDLY;
                        err_nx[1] = 1'b1;
                    end
                end
                PWRDN: begin
                    // rail request drops on the second cycle, so ack is
                    // only trusted from then on
                    if (cnt != '0 && !pgcb_pwr_ack)
                        state_nx = IDLE;
                end
                FORCED:  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        fuse_nx = 1'b0;
        pgcb_nx = 1'b0;
        qui_nx  = 1'b0;
        core_nx = 1'b0;
        side_nx = 1'b0;
        done_nx = 1'b0;
        case (state_nx)
            FUSE:    fuse_nx = 1'b1;
            PWRUP:   pgcb_nx = 1'b1;
            PWRDLY:  pgcb_nx = 1'b1;
            CORE_UP: begin
                pgcb_nx = 1'b1;
                core_nx = 1'b1;
            end
            ACTIVE: begin
                pgcb_nx = 1'b1;
                core_nx = 1'b1;
                side_nx = 1'b1;
                done_nx = 1'b1;
            end
            DRAIN: begin
                pgcb_nx = 1'b1;
                core_nx = 1'b1;
                side_nx = 1'b1;
                qui_nx  = 1'b1;
            end
            PWRDN:   pgcb_nx = (state != PWRDN) & pgcb_pwr_req;
            FORCED:  pgcb_nx = force_pwr_on & ~force_pwr_off;
            default: ;
        endcase
    end

    always_comb begin
        if (state_nx != state)
            cnt_nx = '0;
        else if (cnt == 10'h3ff)
            cnt_nx = cnt;
        else
            cnt_nx = cnt + 10'd1;
    end

    always_ff @(posedge prim_clk or negedge prim_rst_b) begin
        if (!prim_rst_b) begin
            state         <= IDLE;
            cnt           <= '0;
            seq_err       <= '0;
            fuse_pull_req <= 1'b0;
            pgcb_pwr_req  <= 1'b0;
            quiesce_req   <= 1'b0;
            core_rst_b    <= 1'b0;
            side_rst_b    <= 1'b0;
            rst_done      <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            seq_err       <= err_nx;
            fuse_pull_req <= fuse_nx;
            pgcb_pwr_req  <= pgcb_nx;
            quiesce_req   <= qui_nx;
            core_rst_b    <= core_nx;
            side_rst_b    <= side_nx;
            rst_done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_hqm_reset_pwr_sequencer.sv
// tb_hqm_reset_pwr_sequencer: randomized boot, warm, force and power-down
// scenarios; every expected output transition is timestamped and scoreboarded.
`timescale 1ns/1ps
module tb_hqm_reset_pwr_sequencer;

    localparam int PWR_DLY   = 16;
    localparam int SIDE_DLY  = 8;
    localparam int FUSE_TMO  = 1023;
    localparam int DRAIN_TMO = 511;

    localparam int S_FUSE = 0;
    localparam int S_PGCB = 1;
    localparam int S_QUI  = 2;
    localparam int S_CORE = 3;
    localparam int S_SIDE = 4;
    localparam int S_DONE = 5;
    localparam int S_E0   = 6;
    localparam int S_E1   = 7;
    localparam int S_ST   = 8;

    logic       prim_clk = 1'b0;
    logic       prim_rst_b = 1'b0;
    logic       pwr_on_req = 1'b0;
    logic       warm_rst_req = 1'b0;
    logic       fuse_bypass = 1'b0;
    logic       fuse_pull_ack = 1'b0;
    logic       pgcb_pwr_ack = 1'b0;
    logic       quiesce_done = 1'b0;
    logic       force_pwr_on = 1'b0;
    logic       force_pwr_off = 1'b0;
    logic       fuse_pull_req;
    logic       pgcb_pwr_req;
    logic       quiesce_req;
    logic       core_rst_b;
    logic       side_rst_b;
    logic       rst_done;
    logic [1:0] seq_err;
    logic [3:0] seq_state;

    typedef struct {
        int sig;
        int val;
        int t;
    } ev_t;

    ev_t evq[$];
    int  model[9];
    int  cur[9];
    int  prv[9];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    hqm_reset_pwr_sequencer #(
        .PWR_DLY  (PWR_DLY),
        .SIDE_DLY (SIDE_DLY),
        .FUSE_TMO (FUSE_TMO),
        .DRAIN_TMO(DRAIN_TMO)
    ) dut (
        .prim_clk     (prim_clk),
        .prim_rst_b   (prim_rst_b),
        .pwr_on_req   (pwr_on_req),
        .warm_rst_req (warm_rst_req),
        .fuse_bypass  (fuse_bypass),
        .fuse_pull_ack(fuse_pull_ack),
        .pgcb_pwr_ack (pgcb_pwr_ack),
        .quiesce_done (quiesce_done),
        .force_pwr_on (force_pwr_on),
        .force_pwr_off(force_pwr_off),
        .fuse_pull_req(fuse_pull_req),
        .pgcb_pwr_req (pgcb_pwr_req),
        .quiesce_req  (quiesce_req),
        .core_rst_b   (core_rst_b),
        .side_rst_b   (side_rst_b),
        .rst_done     (rst_done),
        .seq_err      (seq_err),
        .seq_state    (seq_state)
    );

    always #5 prim_clk = ~prim_clk;

    always @(posedge prim_clk) cyc <= cyc + 1;

    function automatic string sname(input int i);
        case (i)
            S_FUSE:  return "fuse_pull_req";
            S_PGCB:  return "pgcb_pwr_req";
            S_QUI:   return "quiesce_req";
            S_CORE:  return "core_rst_b";
            S_SIDE:  return "side_rst_b";
            S_DONE:  return "rst_done";
            S_E0:    return "seq_err0";
            S_E1:    return "seq_err1";
            default: return "seq_state";
        endcase
    endfunction

    // monitor: every observed output change must match the oldest
    // pending expectation for that signal, in value and cycle
    always @(negedge prim_clk) begin
        cur[S_FUSE] = int'(fuse_pull_req);
        cur[S_PGCB] = int'(pgcb_pwr_req);
        cur[S_QUI]  = int'(quiesce_req);
        cur[S_CORE] = int'(core_rst_b);
        cur[S_SIDE] = int'(side_rst_b);
        cur[S_DONE] = int'(rst_done);
        cur[S_E0]   = int'(seq_err[0]);
        cur[S_E1]   = int'(seq_err[1]);
        cur[S_ST]   = int'(seq_state);
        if (prim_rst_b) begin
            for (int i = 0; i < 9; i++) begin
                if (cur[i] != prv[i]) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < evq.size(); j++)
                        if (idx < 0 && evq[j].sig == i) idx = j;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL %s unexpected change to %0d at cycle %0d",
                                 sname(i), cur[i], cyc);
                    end else begin
                        if (evq[idx].val != cur[i] || evq[idx].t != cyc) begin
                            errors++;
                            $display("FAIL %s got %0d at cycle %0d, want %0d at cycle %0d",
                                     sname(i), cur[i], cyc, evq[idx].val, evq[idx].t);
                        end
                        evq.delete(idx);
                    end
                end
            end
        end
        prv = cur;
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " fuse_pull_req"}, int'(fuse_pull_req), 0);
        chk({tag, " pgcb_pwr_req"}, int'(pgcb_pwr_req), 0);
        chk({tag, " quiesce_req"}, int'(quiesce_req), 0);
        chk({tag, " core_rst_b"}, int'(core_rst_b), 0);
        chk({tag, " side_rst_b"}, int'(side_rst_b), 0);
        chk({tag, " rst_done"}, int'(rst_done), 0);
        chk({tag, " seq_err"}, int'(seq_err), 0);
        chk({tag, " seq_state"}, int'(seq_state), 0);
    endtask

    // expectation: signal takes value val starting at edge t
    task automatic exp(input int sig, input int val, input int t);
        ev_t e;
        if (model[sig] != val) begin
            e.sig = sig;
            e.val = val;
            e.t   = t;
            evq.push_back(e);
            model[sig] = val;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge prim_clk);
            #1;
        end
    endtask

    task automatic step(input int n);
        wait_to(cyc + n);
    endtask

    // PWRDLY entered at edge s3; stray warm pulse must be ignored
    task automatic tail(input int s3);
        exp(S_ST, 3, s3);
        exp(S_ST, 4, s3 + PWR_DLY);
        exp(S_CORE, 1, s3 + PWR_DLY);
        exp(S_ST, 5, s3 + PWR_DLY + SIDE_DLY);
        exp(S_SIDE, 1, s3 + PWR_DLY + SIDE_DLY);
        exp(S_DONE, 1, s3 + PWR_DLY + SIDE_DLY);
        wait_to(s3 + 3);
        warm_rst_req = 1'b1;
        step(1);
        warm_rst_req = 1'b0;
        wait_to(s3 + PWR_DLY + SIDE_DLY);
    endtask

    // IDLE is left at edge s; fd<0 withholds the fuse ack
    task automatic boot_from(input int s, input bit byp, input int fd, input int pk);
        int s2;
        if (byp) begin
            s2 = s;
        end else begin
            exp(S_ST, 1, s);
            exp(S_FUSE, 1, s);
            if (fd < 0) begin
                s2 = s + FUSE_TMO;
                exp(S_E0, 1, s2);
            end else begin
                s2 = s + fd + 1;
            end
            exp(S_FUSE, 0, s2);
        end
        exp(S_ST, 2, s2);
        exp(S_PGCB, 1, s2);
        if (!byp && fd >= 0) begin
            wait_to(s + fd);
            fuse_pull_ack = 1'b1;
            step(1);
            fuse_pull_ack = 1'b0;
        end
        wait_to(s2 + pk);
        pgcb_pwr_ack = 1'b1;
        tail(s2 + pk + 1);
    endtask

    task automatic cold_boot(input bit byp, input int fd, input int pk);
        fuse_bypass = byp;
        pwr_on_req  = 1'b1;
        boot_from(cyc + 1, byp, fd, pk);
    endtask

    // q<0 never signals quiesce_done, forcing the drain timeout
    task automatic warm(input int q);
        int s;
        int s2;
        s = cyc + 1;
        warm_rst_req = 1'b1;
        exp(S_ST, 6, s);
        exp(S_QUI, 1, s);
        exp(S_DONE, 0, s);
        s2 = (q < 0) ? s + DRAIN_TMO : s + q + 1;
        if (q < 0) exp(S_E1, 1, s2);
        exp(S_QUI, 0, s2);
        exp(S_CORE, 0, s2);
        exp(S_SIDE, 0, s2);
        step(1);
        warm_rst_req = 1'b0;
        wait_to(s2 - 1);
        if (q >= 0) quiesce_done = 1'b1;
        step(1);
        quiesce_done = 1'b0;
        tail(s2);
    endtask

    task automatic ack_fall(input int k);
        int s;
        s = cyc + 1;
        pgcb_pwr_ack = 1'b0;
        exp(S_ST, 2, s);
        exp(S_CORE, 0, s);
        exp(S_SIDE, 0, s);
        exp(S_DONE, 0, s);
        wait_to(s + k);
        pgcb_pwr_ack = 1'b1;
        tail(s + k + 1);
    endtask

    task automatic force_pulse(input bit off, input int len, input bit byp,
                               input int fd, input int pk);
        int s;
        int r;
        s = cyc + 1;
        r = s + len - 1;
        if (off) force_pwr_off = 1'b1;
        else force_pwr_on = 1'b1;
        exp(S_ST, 8, s);
        exp(S_PGCB, off ? 0 : 1, s);
        exp(S_CORE, 0, s);
        exp(S_SIDE, 0, s);
        exp(S_DONE, 0, s);
        exp(S_ST, 0, r + 1);
        exp(S_PGCB, 0, r + 1);
        wait_to(s);
        pgcb_pwr_ack = 1'b0;
        wait_to(r);
        force_pwr_off = 1'b0;
        force_pwr_on  = 1'b0;
        fuse_bypass   = byp;
        boot_from(r + 2, byp, fd, pk);
    endtask

    task automatic power_down(input int k);
        int s;
        s = cyc + 1;
        pwr_on_req = 1'b0;
        exp(S_ST, 7, s);
        exp(S_CORE, 0, s);
        exp(S_SIDE, 0, s);
        exp(S_DONE, 0, s);
        exp(S_PGCB, 0, s + 1);
        exp(S_ST, 0, s + 2 + k);
        wait_to(s + 1 + k);
        pgcb_pwr_ack = 1'b0;
        wait_to(s + 2 + k);
    endtask

    task automatic abort_fuse();
        int s;
        fuse_bypass = 1'b0;
        pwr_on_req  = 1'b1;
        s = cyc + 1;
        exp(S_ST, 1, s);
        exp(S_FUSE, 1, s);
        exp(S_ST, 7, s + 4);
        exp(S_FUSE, 0, s + 4);
        exp(S_ST, 0, s + 6);
        wait_to(s + 3);
        pwr_on_req = 1'b0;
        wait_to(s + 6);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        for (int i = 0; i < 9; i++) model[i] = 0;
        #12;
        chk_zero("reset");
        wait_to(3);
        prim_rst_b = 1'b1;
        step(2);

        for (int it = 0; it < 5; it++) begin
            cold_boot(1'($urandom_range(1, 0)), int'($urandom_range(20, 0)),
                      int'($urandom_range(9, 0)));
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(3, 0))
                    0: warm(int'($urandom_range(15, 0)));
                    1: ack_fall(int'($urandom_range(6, 0)));
                    2: force_pulse(1'b1, int'($urandom_range(30, 2)),
                                   1'($urandom_range(1, 0)),
                                   int'($urandom_range(20, 0)),
                                   int'($urandom_range(9, 0)));
                    default: force_pulse(1'b0, int'($urandom_range(30, 2)),
                                         1'($urandom_range(1, 0)),
                                         int'($urandom_range(20, 0)),
                                         int'($urandom_range(9, 0)));
                endcase
            end
            power_down(int'($urandom_range(5, 0)));
        end

        cold_boot(1'b0, 5, 3);
        warm(10);
        force_pulse(1'b1, 20, 1'b1, 0, 2);
        power_down(0);
        abort_fuse();
        cold_boot(1'b0, -1, 2);
        warm(-1);

        // async reset in the middle of PWRDLY
        s = cyc + 1;
        pgcb_pwr_ack = 1'b0;
        exp(S_ST, 2, s);
        exp(S_CORE, 0, s);
        exp(S_SIDE, 0, s);
        exp(S_DONE, 0, s);
        exp(S_ST, 3, s + 1);
        wait_to(s);
        pgcb_pwr_ack = 1'b1;
        wait_to(s + 6);
        #2;
        prim_rst_b = 1'b0;
        #1;
        chk_zero("async_reset");
        pwr_on_req   = 1'b0;
        pgcb_pwr_ack = 1'b0;
        for (int i = 0; i < 9; i++) model[i] = 0;
        step(2);
        #2;
        prim_rst_b = 1'b1;
        step(4);
        chk_zero("post_reset");

        while (evq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s missing change to %0d at cycle %0d",
                     sname(evq[0].sig), evq[0].val, evq[0].t);
            evq.delete(0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hqm_reset_pwr_sequencer.md
Name: hqm_reset_pwr_sequencer

Overview:
DUT-side reset/power sequencer directly downstream of the reset agent: consumes the power-on, warm-reset, fuse-bypass and force-power controls the agent drives, and stages the internal reset release. Order is fuse pull, then power-gate handshake, then core reset release, then side reset release, then reset-done. Warm reset drains traffic before reasserting resets, and forced power on/off overrides sequencing for the hw-reset-force tests.

Parameters:
PWR_DLY, 16, cycles from power ack to core reset release (range 1..255)
SIDE_DLY, 8, cycles from core release to side reset release (range 1..255)
FUSE_TMO, 1023, max cycles waiting fuse_pull_ack before error (range 1..1023)
DRAIN_TMO, 511, max cycles waiting quiesce_done during warm reset (range 1..1023)

Ports:
prim_clk  input  1  sequencer clock
prim_rst_b  input  1  async active-low reset (powergood-derived)
pwr_on_req  input  1  level; 1 = bring block up, 0 = power down
warm_rst_req  input  1  pulse; request warm reset while ACTIVE
fuse_bypass  input  1  level, sampled in IDLE; 1 = skip fuse pull
fuse_pull_ack  input  1  pulse from fuse controller
pgcb_pwr_ack  input  1  level; power-gate reports rail on
quiesce_done  input  1  level; traffic drained
force_pwr_on  input  1  level override, rail forced on
force_pwr_off  input  1  level override, rail forced off (priority over force_pwr_on)
fuse_pull_req  output  1  fuse pull request, held until ack
pgcb_pwr_req  output  1  power-gate rail request
quiesce_req  output  1  drain request during warm reset
core_rst_b  output  1  core reset, active-low
side_rst_b  output  1  sideband reset, active-low
rst_done  output  1  sequencing complete
seq_err  output  2  sticky error: [0] fuse timeout, [1] drain timeout
seq_state  output  4  current state encoding for debug

Behaviour:
- prim_rst_b low (async): state=IDLE; all outputs 0, which holds core_rst_b and side_rst_b asserted. Counter=0, seq_err=0.
- All outputs are registered. A state change is visible on outputs 1 cycle after the causing input is sampled.
- States and encodings: IDLE=0, FUSE=1, PWRUP=2, PWRDLY=3, CORE_UP=4, ACTIVE=5, DRAIN=6, PWRDN=7, FORCED=8.
- IDLE: if pwr_on_req=1, go to PWRUP when fuse_bypass=1, else go to FUSE.
- FUSE: fuse_pull_req=1 and the counter increments. On fuse_pull_ack go to PWRUP and drop the request. If the counter reaches FUSE_TMO: set seq_err[0], go to PWRUP anyway.
- PWRUP: pgcb_pwr_req=1. When pgcb_pwr_ack=1, go to PWRDLY with the counter cleared.
- PWRDLY: count PWR_DLY cycles, then go to CORE_UP with core_rst_b=1.
- CORE_UP: count SIDE_DLY cycles, then go to ACTIVE with side_rst_b=1 and rst_done=1.
- ACTIVE:
  - warm_rst_req → DRAIN with quiesce_req=1 and rst_done=0.
  - pwr_on_req=0 → PWRDN.
  - If warm_rst_req and pwr_on_req=0 arrive in the same cycle, PWRDN wins.
- DRAIN: on quiesce_done, or when the counter reaches DRAIN_TMO (set seq_err[1]):
  - core_rst_b=0, side_rst_b=0, quiesce_req=0.
  - Go to PWRDLY. Power stays on and the fuse is not re-pulled.
- PWRDN:
  - Cycle 1: core_rst_b=0, side_rst_b=0, rst_done=0.
  - Cycle 2: pgcb_pwr_req=0. Wait for pgcb_pwr_ack=0, then go to IDLE.
- pgcb_pwr_ack falling in any of PWRDLY, CORE_UP, ACTIVE or DRAIN while not forced: reassert both resets immediately (next cycle) and go to PWRUP.
- pwr_on_req falling in FUSE, PWRUP, PWRDLY, CORE_UP or DRAIN: abort to PWRDN. Any pending fuse_pull_req or quiesce_req is dropped.
- FORCED: entered from any state when force_pwr_on or force_pwr_off =1.
  - force_pwr_off: pgcb_pwr_req=0, both resets asserted, rst_done=0.
  - force_pwr_on: pgcb_pwr_req=1, resets asserted.
  - When both forces are 0, go to IDLE.
- Counters: 10-bit, cleared on every state entry, saturate at 1023.
- seq_err bits are sticky until prim_rst_b.
- warm_rst_req outside ACTIVE is ignored and is not queued.

Test Plan:
- Cold boot, fuse_bypass=0, ack after 5 cycles, pgcb_pwr_ack 3 cycles after request, defaults → core_rst_b rises exactly 16 cycles after ack is sampled; side_rst_b and rst_done rise 8 cycles after that; seq_err=0.
- Cold boot, fuse_bypass=1 → fuse_pull_req never asserts; seq_state goes 0→2.
- Fuse ack withheld → seq_err[0]=1 at cycle 1023 of FUSE; sequence continues to ACTIVE.
- Warm reset in ACTIVE, quiesce_done after 10 cycles → both resets low for 16+8 cycles; pgcb_pwr_req stays 1 throughout; rst_done returns to 1.
- force_pwr_off pulsed for 20 cycles during ACTIVE → next cycle pgcb_pwr_req=0 and resets asserted; after release, state=IDLE and re-boots because pwr_on_req=1.
- prim_rst_b asserted mid-PWRDLY → all outputs 0 asynchronously; seq_state=0.
